// File: rtl/flow_led_shifter.sv
// Moves a one-hot light along an LED bank at a fixed step rate, steered by a
// registered 2-bit direction code (00 pause, 01 soft reset, 10 left, 11 right).
module flow_led_shifter #(
    parameter int N_LEDS    = 8,
    parameter int DIV       = 50000000,
    parameter int START_POS = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [1:0]                Dir_Sel,
    output logic [N_LEDS-1:0]         Led,
    output logic [$clog2(N_LEDS)-1:0] Pos,
    output logic                      Tick,
    output logic [1:0]                State
);

    localparam int PW = $clog2(N_LEDS);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [PW-1:0] POS_MAX   = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] POS_START = PW'(START_POS);

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        INIT  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } mode_t;

    function automatic logic [N_LEDS-1:0] onehot(input logic [PW-1:0] p);
        logic [N_LEDS-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    mode_t             dir_q, dir_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              tick_q, tick_d;

    always_comb begin
        dir_d  = mode_t'(Dir_Sel);
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        tick_d = 1'b0;
        case (dir_q)
            HOLD: ;
            INIT: begin
                cnt_d = '0;
                pos_d = POS_START;
            end
            LEFT, RIGHT: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (dir_q == LEFT)
                        pos_d = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
                    else
                        pos_d = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
        // Led is registered alongside Pos so the two can never disagree.
        led_d = onehot(pos_d);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            dir_q  <= HOLD;
            cnt_q  <= '0;
            pos_q  <= POS_START;
            led_q  <= onehot(POS_START);
            tick_q <= 1'b0;
        end else begin
            dir_q  <= dir_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign Led   = led_q;
    assign Pos   = pos_q;
    assign Tick  = tick_q;
    assign State = dir_q;

endmodule

// File: tb/tb_flow_led_shifter.sv
// Bench for flow_led_shifter: directed scenarios plus random direction codes,
// all checked against a cycle-level behavioural model kept here.
module tb_flow_led_shifter;
    localparam int N   = 8;
    localparam int DIV = 4;
    localparam int SP  = 0;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic [1:0]   Dir_Sel = 2'b00;
    logic [N-1:0] Led;
    logic [2:0]   Pos;
    logic         Tick;
    logic [1:0]   State;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_dir, m_cnt, m_pos, m_tick;

    flow_led_shifter #(.N_LEDS(N), .DIV(DIV), .START_POS(SP)) dut (
        .Clk(Clk), .Reset(Reset), .Dir_Sel(Dir_Sel),
        .Led(Led), .Pos(Pos), .Tick(Tick), .State(State)
    );

    always #5 Clk = ~Clk;

    // Apply inputs, take one rising edge, advance the model, settle.
    task automatic cyc(input logic [1:0] d, input bit r);
        Dir_Sel = d;
        Reset   = r;
        @(posedge Clk);
        if (r) begin
            m_dir = 0; m_cnt = 0; m_pos = SP; m_tick = 0;
        end else begin
            m_tick = 0;
            if (m_dir == 1) begin
                m_cnt = 0; m_pos = SP;
            end else if (m_dir >= 2) begin
                if (m_cnt == DIV - 1) begin
                    m_cnt  = 0;
                    m_tick = 1;
                    m_pos  = (m_dir == 2) ? (m_pos + 1) % N : (m_pos + N - 1) % N;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_dir = d;
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(2'b10, 1'b1);
        cyc(2'b11, 1'b1);
        checks++;
        if (Led !== 8'h01 || Pos !== 3'd0 || Tick !== 1'b0 || State !== 2'b00) begin
            errors++;
            $display("FAIL reset: Led=%h Pos=%0d Tick=%b State=%b required Led=01 Pos=0 Tick=0 State=00",
                     Led, Pos, Tick, State);
        end
    endtask

    task automatic test_run_left();
        int ticks = 0;
        cyc(2'b00, 1'b1);
        for (int i = 0; i < 13; i++) begin
            cyc(2'b10, 1'b0);
            if (Tick === 1'b1) ticks++;
            checks++;
            if (Led !== 8'(1 << m_pos) || Pos !== 3'(m_pos) || Tick !== 1'(m_tick) || State !== 2'(m_dir)) begin
                errors++;
                $display("FAIL run_left[%0d]: Led=%h Pos=%0d Tick=%b State=%b required Led=%h Pos=%0d Tick=%0d State=%0d",
                         i, Led, Pos, Tick, State, 8'(1 << m_pos), m_pos, m_tick, m_dir);
            end
        end
        checks++;
        if (Led !== 8'h08 || ticks != 3) begin
            errors++;
            $display("FAIL run_left_end: Led=%h ticks=%0d required Led=08 ticks=3", Led, ticks);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        while (!(m_pos == 7 && m_tick == 1) && n < 200) begin cyc(2'b10, 1'b0); n++; end
        n = 0;
        do begin cyc(2'b10, 1'b0); n++; end while (Tick !== 1'b1 && n < 20);
        checks++;
        if (Led !== 8'h01 || Pos !== 3'd0) begin
            errors++;
            $display("FAIL wrap_left: Led=%h Pos=%0d required Led=01 Pos=0", Led, Pos);
        end
        n = 0;
        do begin cyc(2'b11, 1'b0); n++; end while (Tick !== 1'b1 && n < 20);
        checks++;
        if (Led !== 8'h80 || Pos !== 3'd7) begin
            errors++;
            $display("FAIL wrap_right: Led=%h Pos=%0d required Led=80 Pos=7", Led, Pos);
        end
    endtask

    task automatic test_pause_resume();
        logic [N-1:0] led_s;
        logic [2:0]   pos_s;
        int n = 0;
        int frozen;
        cyc(2'b00, 1'b1);
        while (!(m_dir == 2 && m_cnt == 2) && n < 20) begin cyc(2'b10, 1'b0); n++; end
        cyc(2'b00, 1'b0);  // last edge still running on the registered code
        led_s  = Led;
        pos_s  = Pos;
        frozen = m_cnt;
        for (int i = 0; i < 9; i++) begin
            cyc(2'b00, 1'b0);
            checks++;
            if (Led !== led_s || Pos !== pos_s || Tick !== 1'b0 || State !== 2'b00) begin
                errors++;
                $display("FAIL hold[%0d]: Led=%h Pos=%0d Tick=%b State=%b required Led=%h Pos=%0d Tick=0 State=00",
                         i, Led, Pos, Tick, State, led_s, pos_s);
            end
        end
        n = 0;
        do begin cyc(2'b10, 1'b0); n++; end while (Tick !== 1'b1 && n < 20);
        checks++;
        // one edge to register the code, then DIV-1-Cnt+1 running edges
        if (n != 1 + (DIV - frozen) || Pos !== 3'((pos_s + 1) % N)) begin
            errors++;
            $display("FAIL resume: edges=%0d Pos=%0d required edges=%0d Pos=%0d",
                     n, Pos, 1 + (DIV - frozen), (pos_s + 1) % N);
        end
    endtask

    task automatic test_soft_reset();
        int n = 0;
        cyc(2'b00, 1'b1);
        while (!(m_pos == 5) && n < 100) begin cyc(2'b10, 1'b0); n++; end
        cyc(2'b01, 1'b0);
        cyc(2'b11, 1'b0);
        checks++;
        if (Led !== 8'h01 || Pos !== 3'd0 || Tick !== 1'b0 || State !== 2'b11) begin
            errors++;
            $display("FAIL soft_reset: Led=%h Pos=%0d Tick=%b State=%b required Led=01 Pos=0 Tick=0 State=11",
                     Led, Pos, Tick, State);
        end
        n = 0;
        do begin cyc(2'b11, 1'b0); n++; end while (Tick !== 1'b1 && n < 20);
        checks++;
        if (n != DIV || Led !== 8'h80) begin
            errors++;
            $display("FAIL soft_reset_step: edges=%0d Led=%h required edges=%0d Led=80", n, Led, DIV);
        end
    endtask

    task automatic test_reset_on_step();
        int n = 0;
        cyc(2'b00, 1'b1);
        while (!(m_dir == 2 && m_cnt == 3 && m_pos == 2) && n < 100) begin cyc(2'b10, 1'b0); n++; end
        cyc(2'b10, 1'b1);
        checks++;
        if (Led !== 8'h01 || Pos !== 3'd0 || Tick !== 1'b0 || State !== 2'b00) begin
            errors++;
            $display("FAIL reset_on_step: Led=%h Pos=%0d Tick=%b State=%b required Led=01 Pos=0 Tick=0 State=00",
                     Led, Pos, Tick, State);
        end
    endtask

    task automatic test_dir_change();
        logic [2:0] pos_s;
        int n = 0;
        cyc(2'b00, 1'b1);
        while (!(m_dir == 2 && m_cnt == 1 && m_pos == 3) && n < 100) begin cyc(2'b10, 1'b0); n++; end
        pos_s = Pos;
        n = 0;
        do begin cyc(2'b11, 1'b0); n++; end while (Tick !== 1'b1 && n < 20);
        checks++;
        if (n != 3 || Pos !== 3'((pos_s + N - 1) % N)) begin
            errors++;
            $display("FAIL dir_change: edges=%0d Pos=%0d required edges=3 Pos=%0d", n, Pos, (pos_s + N - 1) % N);
        end
    endtask

    task automatic test_random();
        logic [1:0] d = 2'b10;
        int bad = 0;
        cyc(2'b00, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) d = 2'($urandom_range(0, 3));
            cyc(d, ($urandom_range(0, 99) == 0));
            checks++;
            if (Led !== 8'(1 << m_pos) || Pos !== 3'(m_pos) || Tick !== 1'(m_tick) ||
                State !== 2'(m_dir) || !$onehot(Led)) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d]: Led=%h Pos=%0d Tick=%b State=%b required Led=%h Pos=%0d Tick=%0d State=%0d",
                             i, Led, Pos, Tick, State, 8'(1 << m_pos), m_pos, m_tick, m_dir);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_left();
        test_wrap();
        test_pause_resume();
        test_soft_reset();
        test_reset_on_step();
        test_dir_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
